// File: rtl/max_group_scheduler.sv
// Row-group scheduler for the max-forwarding / accumulate-max pipeline: issues one
// chunk per cycle and tracks groups in flight. Optional counters: MAX_GROUP_SCHED_CNT_EN.
module max_group_scheduler #(
  parameter int ADDR_W   = 10,
  parameter int LEN_MAX  = 13,
  parameter int PIPE_LAT = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [3:0]        i_cmd_len,
  input  logic [ADDR_W-1:0] i_cmd_base,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_valid_max,
  output logic [3:0]        o_length_mode,
  output logic              o_first,
  output logic              o_last,
  output logic              o_acc_rst_loc,
  output logic              o_done,
  output logic              o_err_len,
  output logic              o_busy
`ifdef MAX_GROUP_SCHED_CNT_EN
  ,
  output logic [31:0]       o_group_cnt,
  output logic [15:0]       o_err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [3:0]          len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic [PIPE_LAT-1:0] sr_q, sr_d;

  logic accept;
  logic legal;
  logic issue;
  logic last_chunk;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    addr_d  = addr_q;
    err_d   = err_q;
    sr_d    = sr_q;

    // Ready is also masked during reset so nothing is accepted while state is being cleared.
    o_cmd_ready = !i_rst && !i_stall && ((state_q == S_IDLE) || (state_q == S_GAP));
    accept      = i_cmd_valid && o_cmd_ready;
    legal       = (i_cmd_len != 4'd0) && (i_cmd_len <= 4'(LEN_MAX));
    issue       = (state_q == S_ISSUE);
    last_chunk  = issue && (idx_q == len_q - 4'd1);

    o_rd_en       = issue;
    o_valid_max   = issue;
    o_rd_addr     = addr_q;
    o_first       = issue && (idx_q == 4'd0);
    o_last        = last_chunk;
    o_acc_rst_loc = (state_q == S_GAP);
    o_length_mode = (state_q == S_IDLE) ? 4'd0 : len_q;
    o_done        = sr_q[PIPE_LAT-1];
    o_err_len     = err_q;
    o_busy        = (state_q != S_IDLE) || (|sr_q);

    if (!i_stall) begin
      sr_d  = {sr_q[PIPE_LAT-2:0], last_chunk};
      err_d = accept && !legal;
      unique case (state_q)
        S_IDLE, S_GAP: begin
          state_d = S_IDLE;
          if (accept && legal) begin
            state_d = S_ISSUE;
            idx_d   = 4'd0;
            len_d   = i_cmd_len;
            addr_d  = i_cmd_base;
          end
        end
        S_ISSUE: begin
          // Address wraps modulo 2^ADDR_W by plain truncation.
          addr_d = addr_q + ADDR_W'(1);
          idx_d  = idx_q + 4'd1;
          if (last_chunk) state_d = S_GAP;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample the same old values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      sr_q    <= sr_d;
    end
  end

`ifdef MAX_GROUP_SCHED_CNT_EN
  logic [31:0] grp_cnt_q, grp_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Pulses are held across stalls, so they are counted only on unstalled cycles.
  always_comb begin
    grp_cnt_d = grp_cnt_q;
    err_cnt_d = err_cnt_q;
    if (!i_stall) begin
      if (sr_q[PIPE_LAT-1]) grp_cnt_d = grp_cnt_q + 32'd1;
      if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grp_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      grp_cnt_q <= grp_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_group_cnt = grp_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_max_group_scheduler.sv
// Self-checking bench for max_group_scheduler: directed scenarios then random traffic,
// compared each cycle against a slot-queue model of the issue schedule.
module tb_max_group_scheduler;

  localparam int ADDR_W   = 10;
  localparam int LEN_MAX  = 13;
  localparam int PIPE_LAT = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_len;
  logic [ADDR_W-1:0] cmd_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              valid_max;
  logic [3:0]        length_mode;
  logic              first;
  logic              last;
  logic              acc_rst_loc;
  logic              done;
  logic              err_len;
  logic              busy;
`ifdef MAX_GROUP_SCHED_CNT_EN
  logic [31:0]       group_cnt;
  logic [15:0]       err_cnt;
`endif

  always #5 clk = ~clk;

  max_group_scheduler #(
    .ADDR_W  (ADDR_W),
    .LEN_MAX (LEN_MAX),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_len    (cmd_len),
    .i_cmd_base   (cmd_base),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .o_valid_max  (valid_max),
    .o_length_mode(length_mode),
    .o_first      (first),
    .o_last       (last),
    .o_acc_rst_loc(acc_rst_loc),
    .o_done       (done),
    .o_err_len    (err_len),
    .o_busy       (busy)
`ifdef MAX_GROUP_SCHED_CNT_EN
    ,
    .o_group_cnt  (group_cnt),
    .o_err_cnt    (err_cnt)
`endif
  );

  // One expected output slot per unstalled cycle of activity.
  typedef struct packed {
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic              first;
    logic              last;
    logic              acc;
    logic [3:0]        mode;
  } slot_t;

  slot_t slots[$];
  int    done_at[$];
  int    ucnt;
  logic  err_exp;
  logic [31:0] grp_cnt_exp;
  logic [15:0] err_cnt_exp;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    slots.delete();
    done_at.delete();
    ucnt        = 0;
    err_exp     = 1'b0;
    grp_cnt_exp = '0;
    err_cnt_exp = '0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic cyc(input logic r, input logic s, input logic v,
                     input logic [3:0] len, input logic [ADDR_W-1:0] base,
                     output logic accepted);
    slot_t cur;
    slot_t nw;
    logic  ready_exp;
    logic  done_exp;
    logic  busy_exp;
    @(negedge clk);
    rst       = r;
    stall     = s;
    cmd_valid = v;
    cmd_len   = len;
    cmd_base  = base;
    #1;
    cur       = (slots.size() > 0) ? slots[0] : '0;
    ready_exp = !r && !s && ((slots.size() == 0) || cur.acc);
    done_exp  = 1'b0;
    foreach (done_at[i]) if (done_at[i] == ucnt) done_exp = 1'b1;
    busy_exp  = (slots.size() > 0) || (done_at.size() > 0);

    check("cmd_ready",   32'(cmd_ready),   32'(ready_exp));
    check("rd_en",       32'(rd_en),       32'(cur.rd_en));
    check("valid_max",   32'(valid_max),   32'(cur.rd_en));
    if (cur.rd_en) check("rd_addr", 32'(rd_addr), 32'(cur.addr));
    check("first",       32'(first),       32'(cur.first));
    check("last",        32'(last),        32'(cur.last));
    check("acc_rst_loc", 32'(acc_rst_loc), 32'(cur.acc));
    check("length_mode", 32'(length_mode), 32'(cur.mode));
    check("done",        32'(done),        32'(done_exp));
    check("err_len",     32'(err_len),     32'(err_exp));
    check("busy",        32'(busy),        32'(busy_exp));
`ifdef MAX_GROUP_SCHED_CNT_EN
    check("group_cnt",   group_cnt,        grp_cnt_exp);
    check("err_cnt",     32'(err_cnt),     32'(err_cnt_exp));
`endif

    accepted = v && ready_exp;
    if (r) begin
      model_reset();
    end else if (!s) begin
      if (slots.size() > 0) begin
        cur = slots.pop_front();
        if (cur.last) done_at.push_back(ucnt + PIPE_LAT);
      end
      if (done_exp) grp_cnt_exp++;
      if (err_exp && err_cnt_exp != 16'hFFFF) err_cnt_exp++;
      ucnt++;
      err_exp = accepted && ((len == 4'd0) || (int'(len) > LEN_MAX));
      if (accepted && !err_exp) begin
        for (int i = 0; i < int'(len); i++) begin
          nw       = '0;
          nw.rd_en = 1'b1;
          nw.addr  = base + ADDR_W'(i);
          nw.first = (i == 0);
          nw.last  = (i == int'(len) - 1);
          nw.mode  = len;
          slots.push_back(nw);
        end
        nw      = '0;
        nw.acc  = 1'b1;
        nw.mode = len;
        slots.push_back(nw);
      end
      for (int i = done_at.size() - 1; i >= 0; i--)
        if (done_at[i] < ucnt) done_at.delete(i);
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, '0, a);
  endtask

  // Hold a command valid until accepted, bounded by a cycle budget.
  task automatic send(input logic [3:0] len, input logic [ADDR_W-1:0] base);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 40 && !a; i++) cyc(1'b0, 1'b0, 1'b1, len, base, a);
    check("send_accept", 32'(a), 32'd1);
  endtask

  initial begin
    logic a;
    rst       = 1'b1;
    stall     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_base  = '0;
    repeat (2) @(posedge clk);
    model_reset();
    idle(2);

    // Single group, len 4.
    send(4'd4, 10'h010);
    idle(18);

    // Back-to-back 13 then 1 with valid held.
    send(4'd13, 10'h100);
    send(4'd1, 10'h200);
    idle(18);

    // Illegal lengths.
    send(4'd0, 10'h020);
    send(4'd14, 10'h030);
    idle(3);

    // Stall for 3 cycles after the third chunk.
    send(4'd6, 10'h040);
    idle(3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 4'd0, '0, a);
    idle(20);

    // Address wrap.
    send(4'd4, 10'h3FE);
    idle(18);

    // Reset during chunk 3 of len 8.
    send(4'd8, 10'h050);
    idle(3);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, '0, a);
    idle(20);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 150) == 0, ($urandom % 5) == 0, ($urandom % 2) == 0,
          4'($urandom_range(0, 15)), ADDR_W'($urandom), a);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/max_group_scheduler.md
Name: max_group_scheduler

Overview:
- Sequences row groups of 64-element chunks into the max-forwarding / accumulate-max pipeline.
- Accepts one command per row group: chunk count plus base address.
- Issues one chunk read per cycle and drives the per-chunk control the pipeline needs:
  - valid
  - length mode
  - first/last flags
  - local accumulator reset
- Tracks in-flight groups through the fixed pipeline latency and reports when each group's global max emerges.

Parameters:
ADDR_W, 10, width of chunk buffer read address
LEN_MAX, 13, largest legal chunk count per group (matches 12-stage forwarding depth + 1)
PIPE_LAT, 12, cycles from o_valid_max to global max appearing at pipeline output

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_stall  in  1  global hold; all state and outputs freeze while high
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  command accepted when valid&ready on a clock edge
i_cmd_len  in  4  chunks in group, legal 1..LEN_MAX
i_cmd_base  in  ADDR_W  address of first chunk
o_rd_en  out  1  chunk buffer read strobe
o_rd_addr  out  ADDR_W  chunk address
o_valid_max  out  1  chunk valid toward max tree / forwarding stage
o_length_mode  out  4  current group's i_cmd_len, held for whole group
o_first  out  1  first chunk of group
o_last  out  1  last chunk of group
o_acc_rst_loc  out  1  local reset pulse to accumulate-max unit
o_done  out  1  pulse: global max of a group is at pipeline output
o_err_len  out  1  one-cycle pulse: illegal length command dropped
o_busy  out  1  issuing or any group in flight

Behaviour:
- Reset: all outputs 0; FSM to IDLE; in-flight shift register cleared. Reset mid-group aborts it; no o_done for aborted groups.
- FSM states:
  - IDLE -> ISSUE on accepted legal command.
  - ISSUE: each unstalled cycle issues one chunk. Outputs are o_rd_en=o_valid_max=1, o_rd_addr=base+idx, o_first=(idx==0), o_last=(idx==len-1). idx increments; after the last chunk -> GAP.
  - GAP: exactly one cycle with o_acc_rst_loc=1 and valid/rd_en=0. Then -> ISSUE if a command was accepted in this cycle, else -> IDLE.
- o_cmd_ready is combinational: (state==IDLE || state==GAP) && !i_stall.
  - Throughput: len+1 cycles per group back-to-back.
- Illegal command (len==0 or len>LEN_MAX):
  - Accepted (ready honoured).
  - o_err_len pulses next cycle.
  - Nothing issued; state stays or returns to IDLE.
- Length 1: single cycle with o_first=o_last=1, then GAP.
- Address arithmetic is modulo 2^ADDR_W; base+idx wraps silently.
- o_length_mode is latched at accept and stable through the GAP cycle. It is 0 in IDLE.
- In-flight tracking:
  - PIPE_LAT-bit shift register loaded with o_last.
  - Advances only when !i_stall.
  - o_done = tap PIPE_LAT-1 of the register, i.e. exactly PIPE_LAT unstalled cycles after o_last.
  - Multiple groups may be in flight simultaneously.
- o_busy = (state!=IDLE) || (|shift register).
- i_stall:
  - Registered outputs hold their values; FSM, idx and shift register hold.
  - o_cmd_ready=0.
  - Pulses (o_acc_rst_loc, o_done, o_err_len) stay asserted across the stall. This is acceptable because the downstream enable is ~i_stall.
- Simultaneous accept-in-GAP and o_done: independent, both occur.

Optional Feature:
- Macro MAX_GROUP_SCHED_CNT_EN, when defined:
  - Adds output o_group_cnt (32 bits), counting o_done pulses (wraps at 2^32) and cleared by i_rst.
  - Adds output o_err_cnt (16 bits), counting o_err_len pulses and saturating at 16'hFFFF.
- Undefined: neither port nor the counters exist.

Test Plan:
1. Reset, cmd len=4 base=0x010 -> o_rd_addr 0x010..0x013 on 4 consecutive cycles.
   - o_first on 0x010, o_last on 0x013.
   - o_acc_rst_loc 1 cycle after last.
   - o_done exactly 12 cycles after o_last.
   - o_length_mode=4 throughout.
2. Back-to-back cmds len=13 then len=1, valid held -> second group's o_first issued 1 cycle after GAP.
   - o_done pulses 12 cycles after each o_last (two pulses 2 cycles apart).
3. Cmd len=0, then len=14 -> two o_err_len pulses, no o_rd_en, o_busy stays 0, FSM remains IDLE.
4. len=6 with i_stall high for 3 cycles after chunk 2 -> outputs frozen, no duplicated or skipped addresses.
   - o_done delayed by exactly 3 cycles.
5. base=0x3FE len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
6. i_rst asserted during chunk 3 of len=8 -> next cycle all outputs 0, o_busy=0; no later o_done. With MAX_GROUP_SCHED_CNT_EN, o_group_cnt=0.
